// File: rtl/id_ex_stage_pkg.sv
// Shared core definitions for the ID/EX stage: datapath width, ALU opcodes
// and the field values that make up a pipeline bubble.
package id_ex_stage_pkg;

    localparam int unsigned XLEN = 32;

    // ALU operation codes carried through ID/EX unchanged
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;

    // Bubble field values: write-back is active-low, so 1 means no write
    localparam logic       WB_NONE  = 1'b1;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when an instruction actually reads register rs and it equals rd
    function automatic logic reg_match(input logic uses, input logic [4:0] rs,
                                       input logic [4:0] rd);
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard compare: the instruction in ID reads the destination of a
// load currently sitting in EX. x0 is never a hazard.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_wb_i,
    input  logic [4:0] ex_rd_i,
    output logic       load_use_o
);

    logic w_ex_is_load;
    logic w_src_match;

    // A writing load in EX to a non-zero register, read by the ID instruction
    always_comb begin
        w_ex_is_load = ex_valid_i && ex_mem_read_i && (ex_wb_i != WB_NONE)
                       && (ex_rd_i != REG_ZERO);
        w_src_match  = reg_match(id_uses_rs1_i, id_rs1_i, ex_rd_i)
                       || reg_match(id_uses_rs2_i, id_rs2_i, ex_rd_i);
        load_use_o   = id_valid_i && w_ex_is_load && w_src_match;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Holds on multicycle EX, inserts bubbles on
// flush and load-use, and counts load-use bubbles with saturation.
module id_ex_stage #(
    parameter int unsigned XLEN  = id_ex_stage_pkg::XLEN,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             id_valid_i,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [XLEN-1:0]  id_rs1_data_i,
    input  logic [XLEN-1:0]  id_rs2_data_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic [3:0]       id_alu_op_i,
    input  logic             id_mem_read_i,
    input  logic             id_mem_write_i,
    input  logic             id_wb_i,
    input  logic             ex_busy_i,
    input  logic             flush_i,
    output logic             ex_valid_o,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic [4:0]       ex_rs1_o,
    output logic [4:0]       ex_rs2_o,
    output logic [4:0]       ex_rd_o,
    output logic [XLEN-1:0]  ex_rs1_data_o,
    output logic [XLEN-1:0]  ex_rs2_data_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic [3:0]       ex_alu_op_o,
    output logic             ex_mem_read_o,
    output logic             ex_mem_write_o,
    output logic             ex_wb_o,
    output logic             stall_o,
    output logic             load_use_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    import id_ex_stage_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [XLEN-1:0]  r_imm;
    logic [3:0]       r_alu_op;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_wb;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_load_use;
    logic             w_bubble;
    logic             w_count;

    hazard_detect u_hazard (
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_uses_rs1_i (id_uses_rs1_i),
        .id_uses_rs2_i (id_uses_rs2_i),
        .ex_valid_i    (r_valid),
        .ex_mem_read_i (r_mem_read),
        .ex_wb_i       (r_wb),
        .ex_rd_i       (r_rd),
        .load_use_o    (w_load_use)
    );

    // Priority decode: busy holds, flush beats load-use, load-use stalls ID
    always_comb begin
        w_bubble   = !ex_busy_i && (flush_i || w_load_use);
        w_count    = !ex_busy_i && !flush_i && w_load_use && (r_stall_cnt != '1);
        stall_o    = ex_busy_i || (!flush_i && w_load_use);
        load_use_o = w_load_use;
    end

    // Pipeline register: reset, hold, bubble or capture; saturating counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1       <= REG_ZERO;
            r_rs2       <= REG_ZERO;
            r_rd        <= REG_ZERO;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_alu_op    <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_wb        <= WB_NONE;
            r_stall_cnt <= '0;
        end else if (!ex_busy_i) begin
            if (w_bubble) begin
                r_valid     <= 1'b0;
                r_pc        <= '0;
                r_rs1       <= REG_ZERO;
                r_rs2       <= REG_ZERO;
                r_rd        <= REG_ZERO;
                r_rs1_data  <= '0;
                r_rs2_data  <= '0;
                r_imm       <= '0;
                r_alu_op    <= '0;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_wb        <= WB_NONE;
            end else begin
                r_valid     <= id_valid_i;
                r_pc        <= id_pc_i;
                r_rs1       <= id_rs1_i;
                r_rs2       <= id_rs2_i;
                r_rd        <= id_rd_i;
                r_rs1_data  <= id_rs1_data_i;
                r_rs2_data  <= id_rs2_data_i;
                r_imm       <= id_imm_i;
                r_alu_op    <= id_alu_op_i;
                r_mem_read  <= id_valid_i && id_mem_read_i;
                r_mem_write <= id_valid_i && id_mem_write_i;
                r_wb        <= id_valid_i ? id_wb_i : WB_NONE;
            end
            if (w_count) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

    assign ex_valid_o     = r_valid;
    assign ex_pc_o        = r_pc;
    assign ex_rs1_o       = r_rs1;
    assign ex_rs2_o       = r_rs2;
    assign ex_rd_o        = r_rd;
    assign ex_rs1_data_o  = r_rs1_data;
    assign ex_rs2_data_o  = r_rs2_data;
    assign ex_imm_o       = r_imm;
    assign ex_alu_op_o    = r_alu_op;
    assign ex_mem_read_o  = r_mem_read;
    assign ex_mem_write_o = r_mem_write;
    assign ex_wb_o        = r_wb;
    assign stall_cnt_o    = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage plus a saturation sequence
// on a narrow-counter build.
module tb_id_ex_stage;

    logic        clk;
    logic        reset_i;
    logic        id_valid_i;
    logic [31:0] id_pc_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        id_uses_rs1_i, id_uses_rs2_i;
    logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [3:0]  id_alu_op_i;
    logic        id_mem_read_i, id_mem_write_i, id_wb_i;
    logic        ex_busy_i, flush_i;

    logic        ex_valid_o;
    logic [31:0] ex_pc_o;
    logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic [31:0] ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [3:0]  ex_alu_op_o;
    logic        ex_mem_read_o, ex_mem_write_o, ex_wb_o;
    logic        stall_o, load_use_o;
    logic [31:0] stall_cnt_o;

    logic        s_valid;
    logic [31:0] s_pc;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [31:0] s_d1, s_d2, s_imm;
    logic [3:0]  s_op;
    logic        s_mr, s_mw, s_wb;
    logic        s_stall, s_load_use;
    logic [3:0]  s_cnt;

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.XLEN(32), .CNT_W(32)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_alu_op_i(id_alu_op_i), .id_mem_read_i(id_mem_read_i),
        .id_mem_write_i(id_mem_write_i), .id_wb_i(id_wb_i),
        .ex_busy_i(ex_busy_i), .flush_i(flush_i),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
        .ex_rd_o(ex_rd_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_imm_o(ex_imm_o), .ex_alu_op_o(ex_alu_op_o), .ex_mem_read_o(ex_mem_read_o),
        .ex_mem_write_o(ex_mem_write_o), .ex_wb_o(ex_wb_o),
        .stall_o(stall_o), .load_use_o(load_use_o), .stall_cnt_o(stall_cnt_o)
    );

    id_ex_stage #(.XLEN(32), .CNT_W(4)) u_dut_sat (
        .clk_i(clk), .reset_i(reset_i), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_alu_op_i(id_alu_op_i), .id_mem_read_i(id_mem_read_i),
        .id_mem_write_i(id_mem_write_i), .id_wb_i(id_wb_i),
        .ex_busy_i(ex_busy_i), .flush_i(flush_i),
        .ex_valid_o(s_valid), .ex_pc_o(s_pc), .ex_rs1_o(s_rs1), .ex_rs2_o(s_rs2),
        .ex_rd_o(s_rd), .ex_rs1_data_o(s_d1), .ex_rs2_data_o(s_d2),
        .ex_imm_o(s_imm), .ex_alu_op_o(s_op), .ex_mem_read_o(s_mr),
        .ex_mem_write_o(s_mw), .ex_wb_o(s_wb),
        .stall_o(s_stall), .load_use_o(s_load_use), .stall_cnt_o(s_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst, busy, flush, valid;
        logic [4:0] rs1; logic u1;
        logic [4:0] rs2; logic u2;
        logic [4:0] rd;  logic mr, mw, wb;
        logic [3:0] op;
        logic       e_stall, e_lu;
        logic       e_valid; logic [4:0] e_rd; logic e_wb, e_mr, e_mw;
        logic [3:0] e_op; logic [4:0] e_rs1, e_rs2;
        logic [31:0] e_pc, e_cnt;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, busy, flush, valid,
        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
        input logic [4:0] rd, input logic mr, mw, wb, input logic [3:0] op,
        input logic e_stall, e_lu,
        input logic e_valid, input logic [4:0] e_rd, input logic e_wb, e_mr, e_mw,
        input logic [3:0] e_op, input logic [4:0] e_rs1, e_rs2,
        input logic [31:0] e_pc, e_cnt);
        vec_t v;
        v.rst = rst; v.busy = busy; v.flush = flush; v.valid = valid;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.mr = mr; v.mw = mw; v.wb = wb; v.op = op;
        v.e_stall = e_stall; v.e_lu = e_lu;
        v.e_valid = e_valid; v.e_rd = e_rd; v.e_wb = e_wb; v.e_mr = e_mr; v.e_mw = e_mw;
        v.e_op = e_op; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_pc = e_pc; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, busy, flush, valid,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic mr, mw, wb,
                         input logic [3:0] op, input logic [31:0] pc);
        reset_i = rst; ex_busy_i = busy; flush_i = flush; id_valid_i = valid;
        id_rs1_i = rs1; id_uses_rs1_i = u1; id_rs2_i = rs2; id_uses_rs2_i = u2;
        id_rd_i = rd; id_mem_read_i = mr; id_mem_write_i = mw; id_wb_i = wb;
        id_alu_op_i = op; id_pc_i = pc;
        id_rs1_data_i = pc + 32'h1000_0000;
        id_rs2_data_i = pc + 32'h2000_0000;
        id_imm_i      = ~pc;
    endtask

    vec_t tbl[22];

    initial begin
        tbl[0]  = mk(1,0,0,0, 0,0,0,0, 0,0,0,1,4'h0, 0,0, 0,0,1,0,0,4'h0,0,0,32'h0,  0);
        tbl[1]  = mk(0,0,0,1, 1,1,2,1, 5,0,0,0,4'h3, 0,0, 1,5,0,0,0,4'h3,1,2,32'h104,0);
        tbl[2]  = mk(0,0,0,1, 5,1,0,0, 7,1,0,0,4'h0, 0,0, 1,7,0,1,0,4'h0,5,0,32'h108,0);
        tbl[3]  = mk(0,0,0,1, 7,1,0,0, 8,0,0,0,4'h1, 1,1, 0,0,1,0,0,4'h0,0,0,32'h0,  1);
        tbl[4]  = mk(0,0,0,1, 7,1,0,0, 8,0,0,0,4'h1, 0,0, 1,8,0,0,0,4'h1,7,0,32'h110,1);
        tbl[5]  = mk(0,0,0,1, 0,0,0,0, 7,1,0,0,4'h0, 0,0, 1,7,0,1,0,4'h0,0,0,32'h114,1);
        tbl[6]  = mk(0,0,0,1, 3,1,7,0, 9,0,0,0,4'h2, 0,0, 1,9,0,0,0,4'h2,3,7,32'h118,1);
        tbl[7]  = mk(0,0,0,1, 0,0,0,0, 0,1,0,0,4'h0, 0,0, 1,0,0,1,0,4'h0,0,0,32'h11C,1);
        tbl[8]  = mk(0,0,0,1, 0,1,0,1,10,0,0,0,4'h4, 0,0, 1,10,0,0,0,4'h4,0,0,32'h120,1);
        tbl[9]  = mk(0,1,1,1,10,1,0,0,11,0,0,0,4'h5, 1,0, 1,10,0,0,0,4'h4,0,0,32'h120,1);
        tbl[10] = mk(0,1,1,1,10,1,0,0,11,0,0,0,4'h5, 1,0, 1,10,0,0,0,4'h4,0,0,32'h120,1);
        tbl[11] = mk(0,1,1,1,10,1,0,0,11,0,0,0,4'h5, 1,0, 1,10,0,0,0,4'h4,0,0,32'h120,1);
        tbl[12] = mk(0,0,1,1,10,1,0,0,11,0,0,0,4'h5, 0,0, 0,0,1,0,0,4'h0,0,0,32'h0,  1);
        tbl[13] = mk(0,0,0,1, 0,0,0,0, 7,1,0,0,4'h0, 0,0, 1,7,0,1,0,4'h0,0,0,32'h134,1);
        tbl[14] = mk(0,0,1,1, 7,1,0,0,12,0,0,0,4'h6, 0,1, 0,0,1,0,0,4'h0,0,0,32'h0,  1);
        tbl[15] = mk(0,0,0,1, 0,0,0,0, 7,1,0,0,4'h0, 0,0, 1,7,0,1,0,4'h0,0,0,32'h13C,1);
        tbl[16] = mk(1,1,0,1, 0,0,0,0, 7,1,0,0,4'h0, 1,0, 0,0,1,0,0,4'h0,0,0,32'h0,  0);
        tbl[17] = mk(0,0,0,0, 2,1,3,1,13,1,1,0,4'h7, 0,0, 0,13,1,0,0,4'h7,2,3,32'h144,0);
        tbl[18] = mk(0,0,0,1, 0,0,0,0, 7,1,0,0,4'h0, 0,0, 1,7,0,1,0,4'h0,0,0,32'h148,0);
        tbl[19] = mk(0,0,0,1, 1,0,7,1,14,0,0,0,4'h8, 1,1, 0,0,1,0,0,4'h0,0,0,32'h0,  1);
        tbl[20] = mk(0,0,0,1, 1,0,7,1,14,0,0,0,4'h8, 0,0, 1,14,0,0,0,4'h8,1,7,32'h150,1);
        tbl[21] = mk(0,0,0,1, 2,1,4,1, 0,0,1,1,4'h0, 0,0, 1,0,1,0,1,4'h0,2,4,32'h154,1);

        // Initial reset cycle so that register state is defined before checks
        drive(1,0,0,0, 0,0,0,0, 0,0,0,1,4'h0, 32'h0);
        @(posedge clk);

        for (int i = 0; i < 22; i++) begin
            logic [31:0] pc;
            string tag;
            pc = 32'h100 + 32'(i) * 4;
            tag = $sformatf("row%0d", i);
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].busy, tbl[i].flush, tbl[i].valid,
                  tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2,
                  tbl[i].rd, tbl[i].mr, tbl[i].mw, tbl[i].wb, tbl[i].op, pc);
            #1;
            chk({tag, " stall_o"},    32'(stall_o),    32'(tbl[i].e_stall));
            chk({tag, " load_use_o"}, 32'(load_use_o), 32'(tbl[i].e_lu));
            @(posedge clk);
            #1;
            chk({tag, " ex_valid"},   32'(ex_valid_o),     32'(tbl[i].e_valid));
            chk({tag, " ex_rd"},      32'(ex_rd_o),        32'(tbl[i].e_rd));
            chk({tag, " ex_wb"},      32'(ex_wb_o),        32'(tbl[i].e_wb));
            chk({tag, " ex_mem_rd"},  32'(ex_mem_read_o),  32'(tbl[i].e_mr));
            chk({tag, " ex_mem_wr"},  32'(ex_mem_write_o), 32'(tbl[i].e_mw));
            chk({tag, " ex_alu_op"},  32'(ex_alu_op_o),    32'(tbl[i].e_op));
            chk({tag, " ex_rs1"},     32'(ex_rs1_o),       32'(tbl[i].e_rs1));
            chk({tag, " ex_rs2"},     32'(ex_rs2_o),       32'(tbl[i].e_rs2));
            chk({tag, " ex_pc"},      ex_pc_o,             tbl[i].e_pc);
            chk({tag, " ex_rs1_data"}, ex_rs1_data_o,
                (tbl[i].e_pc == 0) ? 32'h0 : tbl[i].e_pc + 32'h1000_0000);
            chk({tag, " ex_rs2_data"}, ex_rs2_data_o,
                (tbl[i].e_pc == 0) ? 32'h0 : tbl[i].e_pc + 32'h2000_0000);
            chk({tag, " ex_imm"},     ex_imm_o, (tbl[i].e_pc == 0) ? 32'h0 : ~tbl[i].e_pc);
            chk({tag, " stall_cnt"},  stall_cnt_o, tbl[i].e_cnt);
        end

        // Saturation: 16 load-use bubbles; the 4-bit counter must stop at F
        @(negedge clk);
        drive(1,0,0,0, 0,0,0,0, 0,0,0,1,4'h0, 32'h200);
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            drive(0,0,0,1, 0,0,0,0, 7,1,0,0,4'h0, 32'h300);
            @(negedge clk);
            drive(0,0,0,1, 7,1,0,0, 8,0,0,0,4'h1, 32'h304);
            #1;
            if (k == 16) begin
                chk("sat load_use_o", 32'(s_load_use), 32'd1);
                chk("sat stall_o",    32'(s_stall),    32'd1);
            end
            @(posedge clk);
            #1;
            if (k == 15) chk("sat cnt at 15", 32'(s_cnt), 32'hF);
            if (k == 16) begin
                chk("sat cnt holds", 32'(s_cnt), 32'hF);
                chk("wide cnt 16",   stall_cnt_o, 32'd16);
                chk("sat bubble wb", 32'(s_wb),   32'd1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage core, with load-use hazard detection.
- Captures decoded operands and control from ID and presents them to EX.
- Its ex_rs1_o, ex_rs2_o, ex_rd_o and ex_wb_o feed the EX-stage forwarding logic and the EX/MEM register.
- Generates the IF/ID stall and inserts bubbles for load-use hazards, taken-branch flushes and multicycle EX holds.

Parameters:
- XLEN, 32, datapath width for PC, operands and immediate.
- CNT_W, 32, width of the saturating load-use stall counter.

Ports:
- clk_i  input  1  core clock.
- reset_i  input  1  synchronous active-high reset.
- id_valid_i  input  1  ID holds a real instruction.
- id_pc_i  input  XLEN  PC of the ID instruction.
- id_rs1_i  input  5  source register 1 index.
- id_rs2_i  input  5  source register 2 index.
- id_rd_i  input  5  destination register index.
- id_uses_rs1_i  input  1  instruction reads rs1.
- id_uses_rs2_i  input  1  instruction reads rs2.
- id_rs1_data_i  input  XLEN  register file read data 1.
- id_rs2_data_i  input  XLEN  register file read data 2.
- id_imm_i  input  XLEN  decoded immediate.
- id_alu_op_i  input  4  ALU operation code.
- id_mem_read_i  input  1  instruction is a load.
- id_mem_write_i  input  1  instruction is a store.
- id_wb_i  input  1  register write-back, active-low (0 = write).
- ex_busy_i  input  1  multicycle EX operation in progress; hold ID/EX.
- flush_i  input  1  taken branch/jump resolved in EX; kill the ID instruction.
- ex_valid_o, ex_pc_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_alu_op_o, ex_mem_read_o, ex_mem_write_o, ex_wb_o  output  (same widths as the id_* inputs)  registered copies of the id_* inputs.
- stall_o  output  1  combinational; hold PC and IF/ID this cycle.
- load_use_o  output  1  combinational; load-use hazard detected this cycle.
- stall_cnt_o  output  CNT_W  count of load-use bubbles inserted.

Behaviour:
- Reset (reset_i=1 at a clk_i edge):
  - All ex_* outputs go to 0, except ex_wb_o=1 (no write).
  - stall_cnt_o goes to 0.
  - Reset takes priority over every other input, including in the middle of a hold.
- Bubble: ex_valid_o=0, ex_wb_o=1, ex_mem_read_o=0, ex_mem_write_o=0, ex_rd_o=0. The other ex_* fields are don't-care; drive them to 0.
- Load-use detection (combinational) is asserted when all of the following hold:
  - id_valid_i=1.
  - ex_valid_o=1, ex_mem_read_o=1, ex_wb_o=0 and ex_rd_o!=0.
  - Either (id_uses_rs1_i && id_rs1_i==ex_rd_o) or (id_uses_rs2_i && id_rs2_i==ex_rd_o).
- Per-edge update, in priority order:
  1. reset_i → reset values.
  2. ex_busy_i → hold all ex_* unchanged. stall_o=1. flush_i and load-use are ignored this cycle; EX must keep flush_i asserted until busy drops.
  3. flush_i → load a bubble. stall_o=0.
  4. load-use → load a bubble. stall_o=1. stall_cnt_o increments.
  5. Otherwise → capture all id_* inputs; ex_valid_o=id_valid_i. stall_o=0.
- Latency: one cycle from ID to EX. A load-use stall lasts exactly one cycle; the next cycle the load is in MEM and the hazard clears by itself.
- If id_valid_i=0, capture anyway with ex_valid_o=0, and force ex_wb_o=1 and mem_read/mem_write to 0.
- stall_cnt_o saturates at all-ones and does not wrap.
- x0 never triggers a hazard (ex_rd_o!=0 check).
- stall_o and load_use_o are pure functions of the current inputs and register state; no extra pipeline delay.

Decomposition:
- Shared core package:
  - XLEN.
  - ALU opcode constants.
  - Bubble constants: WB_NONE = 1'b1, REG_ZERO = 5'd0.
- Sub-module hazard_detect: pure combinational load-use compare, outputs load_use_o. The pipeline register, priority logic and counter stay in id_ex_stage.

Test Plan:
1. Reset then release; drive id_valid_i=1, id_rd_i=5, id_wb_i=0, id_alu_op_i=4'h3 → next cycle ex_valid_o=1, ex_rd_o=5, ex_wb_o=0, ex_alu_op_o=4'h3; during reset ex_wb_o=1 and stall_cnt_o=0.
2. Load to x7 in EX; ID instruction uses rs1=7 → load_use_o=1, stall_o=1 for one cycle, bubble in EX (ex_valid_o=0, ex_wb_o=1), stall_cnt_o=1. Following cycle: instruction captured, stall_o=0.
3. Load to x7 in EX; ID has rs2=7 but id_uses_rs2_i=0 → no stall. Load to x0 with rs1=0 → no stall.
4. ex_busy_i=1 for 3 cycles with flush_i=1 → ex_* frozen and stall_o=1 all three cycles. Busy drops with flush_i still 1 → bubble loaded, stall_o=0.
5. flush_i=1 and load-use in the same cycle → bubble loaded, stall_o=0, stall_cnt_o unchanged.
6. Preload stall_cnt_o to all-ones (CNT_W=4 build: 4'hF), trigger load-use → stall_cnt_o stays 4'hF.
